// File: rtl/multi_seq_pkg.sv
// Shared types and helpers for the multi-pattern serial sequence detector.
// Optional match counters are enabled with MULTI_SEQ_MATCH_CNT_EN (see top).
package multi_seq_pkg;

    localparam int MAX_PAT_LEN = 16;
    localparam int MAX_NUM_PAT = 8;
    localparam int LEN_W       = $clog2(MAX_PAT_LEN + 1);
    // Compare width covers the full history plus the incoming bit.
    localparam int CMP_W       = MAX_PAT_LEN + 1;

    typedef struct packed {
        logic [MAX_PAT_LEN-1:0] pat;
        logic [LEN_W-1:0]       len;
        logic                   ovl;
    } ch_cfg_t;

    // True when the low len bits of hist equal the low len bits of pat.
    function automatic logic masked_eq(
        input logic [CMP_W-1:0]       hist,
        input logic [MAX_PAT_LEN-1:0] pat,
        input logic [LEN_W-1:0]       len
    );
        logic [CMP_W-1:0] mask;
        for (int i = 0; i < CMP_W; i++) begin
            mask[i] = (i < int'(len));
        end
        return ((hist ^ {1'b0, pat}) & mask) == '0;
    endfunction

endpackage

// File: rtl/seq_channel.sv
// One pattern channel: config, fill counter, length-masked compare and match pulse.
// Carries a saturating match counter when MULTI_SEQ_MATCH_CNT_EN is defined.
module seq_channel
    import multi_seq_pkg::*;
#(
    parameter int LW = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_valid,
    input  logic             cfg_wr,
    input  ch_cfg_t          cfg_in,
    input  logic [CMP_W-1:0] hist_next,
`ifdef MULTI_SEQ_MATCH_CNT_EN
    input  logic             cnt_clr,
    output logic [7:0]       match_cnt,
`endif
    output logic             z
);

    ch_cfg_t       cfg;
    logic [LW-1:0] fill;
    logic          match;

    always_comb begin
        // NOTE: default first so every path assigns match and no latch is inferred.
        match = 1'b0;
        if (x_valid && !cfg_wr && (cfg.len != '0) &&
            (int'(fill) + 1 >= int'(cfg.len))) begin
            match = masked_eq(hist_next, cfg.pat, cfg.len);
        end
    end

    // NOTE: config is a few flops, not a RAM, so it is reset like any other state;
    // non-blocking assignments keep every register update race-free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg <= '0;
        end else if (cfg_wr) begin
            cfg <= cfg_in;
        end
    end

    // A non-overlap match restarts the count so a full new pattern is required.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill <= '0;
        end else if (cfg_wr) begin
            fill <= '0;
        end else if (match && !cfg.ovl) begin
            fill <= '0;
        end else if (x_valid && (LEN_W'(fill) < cfg.len)) begin
            fill <= fill + LW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z <= 1'b0;
        end else begin
            z <= match;
        end
    end

`ifdef MULTI_SEQ_MATCH_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (cnt_clr) begin
            match_cnt <= '0;
        end else if (match && (match_cnt != 8'hFF)) begin
            match_cnt <= match_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: rtl/multi_seq_detector.sv
// Serial detector for NUM_PAT programmable patterns sharing one history register.
// Define MULTI_SEQ_MATCH_CNT_EN to add per-channel match counters and cnt_clr.
module multi_seq_detector
    import multi_seq_pkg::*;
#(
    parameter  int NUM_PAT = 2,
    parameter  int PAT_LEN = 4,
    parameter  int LW      = $clog2(PAT_LEN + 1),
    localparam int SEL_W   = (NUM_PAT > 1) ? $clog2(NUM_PAT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 X,
    input  logic                 x_valid,
    input  logic                 cfg_we,
    input  logic [SEL_W-1:0]     cfg_sel,
    input  logic [PAT_LEN-1:0]   cfg_pat,
    input  logic [LW-1:0]        cfg_len,
    input  logic                 cfg_ovl,
`ifdef MULTI_SEQ_MATCH_CNT_EN
    input  logic                 cnt_clr,
    output logic [NUM_PAT*8-1:0] match_cnt,
`endif
    output logic [NUM_PAT-1:0]   Z
);

    logic [PAT_LEN-1:0] hist;
    logic [PAT_LEN:0]   hist_next;
    ch_cfg_t            cfg_in;

    assign hist_next = {hist, X};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist <= '0;
        end else if (x_valid) begin
            hist <= hist_next[PAT_LEN-1:0];
        end
    end

    // Lengths beyond the history depth are clamped at write time.
    always_comb begin
        cfg_in.pat = MAX_PAT_LEN'(cfg_pat);
        cfg_in.len = LEN_W'((cfg_len > LW'(PAT_LEN)) ? LW'(PAT_LEN) : cfg_len);
        cfg_in.ovl = cfg_ovl;
    end

    for (genvar i = 0; i < NUM_PAT; i++) begin : g_ch
        logic wr;
        // Selects at or above NUM_PAT match no channel and are dropped.
        assign wr = cfg_we && (cfg_sel == SEL_W'(i));

        seq_channel #(
            .LW (LW)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .x_valid   (x_valid),
            .cfg_wr    (wr),
            .cfg_in    (cfg_in),
            .hist_next (CMP_W'(hist_next)),
`ifdef MULTI_SEQ_MATCH_CNT_EN
            .cnt_clr   (cnt_clr),
            .match_cnt (match_cnt[i*8 +: 8]),
`endif
            .z         (Z[i])
        );
    end

endmodule

// File: tb/tb_multi_seq_detector.sv
// Directed self-checking bench for multi_seq_detector (NUM_PAT=2, PAT_LEN=4).
// Also exercises the match counters when MULTI_SEQ_MATCH_CNT_EN is defined.
module tb_multi_seq_detector;

    localparam int NUM_PAT = 2;
    localparam int PAT_LEN = 4;
    localparam int LW      = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               X;
    logic               x_valid;
    logic               cfg_we;
    logic               cfg_sel;
    logic [PAT_LEN-1:0] cfg_pat;
    logic [LW-1:0]      cfg_len;
    logic               cfg_ovl;
    logic [NUM_PAT-1:0] Z;
`ifdef MULTI_SEQ_MATCH_CNT_EN
    logic                 cnt_clr;
    logic [NUM_PAT*8-1:0] match_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    multi_seq_detector #(
        .NUM_PAT (NUM_PAT),
        .PAT_LEN (PAT_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .X         (X),
        .x_valid   (x_valid),
        .cfg_we    (cfg_we),
        .cfg_sel   (cfg_sel),
        .cfg_pat   (cfg_pat),
        .cfg_len   (cfg_len),
        .cfg_ovl   (cfg_ovl),
`ifdef MULTI_SEQ_MATCH_CNT_EN
        .cnt_clr   (cnt_clr),
        .match_cnt (match_cnt),
`endif
        .Z         (Z)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; return just after the rising edge.
    task automatic step(input logic xv, input logic xb, input logic we, input logic sel,
                        input logic [PAT_LEN-1:0] pat, input logic [LW-1:0] len, input logic ovl);
        @(negedge clk);
        x_valid = xv;
        X       = xb;
        cfg_we  = we;
        cfg_sel = sel;
        cfg_pat = pat;
        cfg_len = len;
        cfg_ovl = ovl;
        @(posedge clk);
        #1;
        x_valid = 1'b0;
        cfg_we  = 1'b0;
    endtask

    task automatic program_ch(input logic sel, input logic [PAT_LEN-1:0] pat,
                              input logic [LW-1:0] len, input logic ovl);
        step(1'b0, 1'b0, 1'b1, sel, pat, len, ovl);
    endtask

    // bits: characters sent oldest first; zexp: expected Z per bit as a digit 0..3.
    task automatic run_seq(input string tag, input string bits, input string zexp);
        for (int i = 0; i < bits.len(); i++) begin
            step(1'b1, bits[i] == "1", 1'b0, 1'b0, '0, '0, 1'b0);
            check($sformatf("%s[%0d]", tag, i), 32'(Z), 32'(zexp[i] - 8'd48));
        end
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s[%0d]", tag, i), 32'(Z), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b1;
        X       = 1'b0;
        x_valid = 1'b0;
        cfg_we  = 1'b0;
        cfg_sel = 1'b0;
        cfg_pat = '0;
        cfg_len = '0;
        cfg_ovl = 1'b0;
`ifdef MULTI_SEQ_MATCH_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset_z", 32'(Z), 32'd0);
`ifdef MULTI_SEQ_MATCH_CNT_EN
        check("reset_cnt", 32'(match_cnt), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Overlapping 010 on channel 0.
        program_ch(1'b0, 4'b0010, 3'd3, 1'b1);
        run_seq("ovl", "001010", "000101");

        // Non-overlapping 100 on channel 1, channel 0 disabled.
        program_ch(1'b0, 4'b0000, 3'd0, 1'b0);
        program_ch(1'b1, 4'b0100, 3'd3, 1'b0);
        run_seq("novl", "10010010", "00200200");

        // Both channels on one shared history.
        program_ch(1'b0, 4'b0010, 3'd3, 1'b1);
        program_ch(1'b1, 4'b0100, 3'd3, 1'b0);
        run_seq("both", "0100", "0012");

        // Stall of x_valid inside a pattern.
        program_ch(1'b0, 4'b0010, 3'd3, 1'b1);
        program_ch(1'b1, 4'b0100, 3'd3, 1'b0);
        run_seq("gap_a", "01", "00");
        idle_check("gap_idle", 3);
        run_seq("gap_b", "0", "1");

        // Reset drops Z asynchronously and wipes config and progress.
        program_ch(1'b0, 4'b0010, 3'd3, 1'b1);
        program_ch(1'b1, 4'b0100, 3'd3, 1'b0);
        run_seq("pre_rst", "010", "001");
        #1 rst = 1'b1;
        #1 check("rst_async_z", 32'(Z), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_seq("cfg_cleared", "010", "000");
        program_ch(1'b0, 4'b0010, 3'd3, 1'b1);
        run_seq("mid_a", "01", "00");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        program_ch(1'b0, 4'b0010, 3'd3, 1'b1);
        run_seq("mid_b", "010", "001");

        // Config write to channel 0 on its completing bit; channel 1 unaffected.
        program_ch(1'b0, 4'b0010, 3'd3, 1'b1);
        program_ch(1'b1, 4'b0010, 3'd3, 1'b1);
        run_seq("coin_a", "01", "00");
        step(1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 3'd3, 1'b1);
        check("coin_hit", 32'(Z), 32'd2);
        run_seq("coin_b", "1010", "0203");

        // Single-bit detector and length clamp (7 -> 4).
        program_ch(1'b0, 4'b0001, 3'd1, 1'b0);
        program_ch(1'b1, 4'b1011, 3'd7, 1'b1);
        run_seq("len1_clamp", "1011", "1013");

`ifdef MULTI_SEQ_MATCH_CNT_EN
        @(negedge clk);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        check("cnt_clr0", 32'(match_cnt), 32'd0);
        run_seq("cnt5", "11111", "11111");
        check("cnt_five", 32'(match_cnt), 32'h0005);
        program_ch(1'b0, 4'b0001, 3'd1, 1'b0);
        check("cnt_keep_cfg", 32'(match_cnt), 32'h0005);
        for (int i = 0; i < 300; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        end
        check("cnt_sat", 32'(match_cnt), 32'h00FF);
        @(negedge clk);
        cnt_clr = 1'b1;
        x_valid = 1'b1;
        X       = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        x_valid = 1'b0;
        check("cnt_clr_wins", 32'(match_cnt), 32'd0);
        check("cnt_clr_z", 32'(Z), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
